// File: rtl/hci_fault_manager.sv
// Fault collection for the HCI copy/compare checkers: sticky status, saturating counters,
// irq/escalation, plus a self-test sequencer that injects a fault into each checker in turn.
module hci_fault_manager #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH-1:0]       fault_i,
    input  logic [N_CH-1:0]       mask_i,
    input  logic [N_CH-1:0]       clear_i,
    input  logic [CNT_W-1:0]      threshold_i,
    input  logic                  selftest_start_i,
    output logic [N_CH-1:0]       inject_o,
    output logic [N_CH-1:0]       status_o,
    output logic [N_CH*CNT_W-1:0] count_o,
    output logic                  irq_o,
    output logic                  escalate_o,
    output logic                  selftest_busy_o,
    output logic                  selftest_done_o,
    output logic [N_CH-1:0]       selftest_fail_o,
    output logic                  selftest_pass_o
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N_CH-1:0] FIRST_CH = N_CH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StInject,
        StWait,
        StGuard,
        StDone
    } state_e;

    state_e           state_q;
    logic [CH_W-1:0]  ch_q;
    logic [WC_W-1:0]  wcnt_q;
    logic [N_CH-1:0]  inject_q;
    logic [N_CH-1:0]  fail_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [N_CH-1:0]  status_q, status_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic             escalate_q, escalate_d;
    logic [N_CH-1:0]  target;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  over;

    // One-hot of the channel under test; only meaningful while busy.
    always_comb begin
        target = '0;
        for (int c = 0; c < N_CH; c++) begin
            target[c] = busy_q && (ch_q == CH_W'(c));
        end
    end

    assign eligible = fault_i & ~mask_i & ~target;

    always_comb begin
        status_d = status_q;
        over     = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clear_i[c]) begin
                status_d[c] = 1'b0;
                cnt_d[c]    = '0;
            end else if (eligible[c]) begin
                status_d[c] = 1'b1;
                if (cnt_q[c] != {CNT_W{1'b1}}) begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
            over[c] = (threshold_i != '0) && (cnt_d[c] >= threshold_i);
        end
        escalate_d = escalate_q | (|over);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q   <= '0;
            escalate_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            status_q   <= status_d;
            escalate_q <= escalate_d;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Self-test sequencer; all of its outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            wcnt_q   <= '0;
            inject_q <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            inject_q <= '0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (selftest_start_i) begin
                        ch_q     <= '0;
                        fail_q   <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        inject_q <= FIRST_CH;
                        state_q  <= StInject;
                    end
                end
                StInject: begin
                    wcnt_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (fault_i[ch_q]) begin
                        state_q <= StGuard;
                    end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                        fail_q[ch_q] <= 1'b1;
                        state_q      <= StGuard;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                end
                StGuard: begin
                    if (ch_q == CH_W'(N_CH - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        ch_q     <= ch_q + CH_W'(1);
                        inject_q <= target << 1;
                        state_q  <= StInject;
                    end
                end
                StDone: begin
                    pass_q  <= (fail_q == '0);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            count_o[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    assign inject_o        = inject_q;
    assign status_o        = status_q;
    assign irq_o           = |(status_q & ~mask_i);
    assign escalate_o      = escalate_q;
    assign selftest_busy_o = busy_q;
    assign selftest_done_o = done_q;
    assign selftest_fail_o = fail_q;
    assign selftest_pass_o = pass_q;

endmodule

// File: tb/tb_hci_fault_manager.sv
// Randomised bench for hci_fault_manager against a cycle-level behavioural model of the
// counting rules and a schedule-based model of the self-test sequence.
module tb_hci_fault_manager;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 15;
    localparam int          MAXC    = 255;
    localparam int          ECHO_D  = 2;

    logic                  clk;
    logic                  rst_i;
    logic [N_CH-1:0]       fault_i, mask_i, clear_i;
    logic [CNT_W-1:0]      threshold_i;
    logic                  selftest_start_i;
    logic [N_CH-1:0]       inject_o, status_o, selftest_fail_o;
    logic [N_CH*CNT_W-1:0] count_o;
    logic                  irq_o, escalate_o, selftest_busy_o, selftest_done_o, selftest_pass_o;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [N_CH-1:0] m_status;
    int              m_cnt [N_CH];
    bit              m_esc;
    logic [N_CH-1:0] m_supp;

    hci_fault_manager #(.N_CH(N_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .fault_i         (fault_i),
        .mask_i          (mask_i),
        .clear_i         (clear_i),
        .threshold_i     (threshold_i),
        .selftest_start_i(selftest_start_i),
        .inject_o        (inject_o),
        .status_o        (status_o),
        .count_o         (count_o),
        .irq_o           (irq_o),
        .escalate_o      (escalate_o),
        .selftest_busy_o (selftest_busy_o),
        .selftest_done_o (selftest_done_o),
        .selftest_fail_o (selftest_fail_o),
        .selftest_pass_o (selftest_pass_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_CH*CNT_W-1:0] exp_count();
        logic [N_CH*CNT_W-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        return v;
    endfunction

    // Advance the model with this cycle's inputs, then let the DUT take the edge.
    task automatic tick();
        if (rst_i) begin
            m_status = '0;
            m_esc    = 1'b0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (clear_i[c]) begin
                    m_status[c] = 1'b0;
                    m_cnt[c]    = 0;
                end else if (fault_i[c] && !mask_i[c] && !m_supp[c]) begin
                    m_status[c] = 1'b1;
                    if (m_cnt[c] < MAXC) m_cnt[c]++;
                end
                if (threshold_i != 0 && m_cnt[c] >= int'(threshold_i)) m_esc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; fault_i = '0; mask_i = '0; clear_i = '0; selftest_start_i = 1'b0;
        m_supp = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        threshold_i = '0;
        do_reset();
        n_cmp++; if (status_o !== '0) begin n_err++; $display("FAIL reset_status got %h exp 0", status_o); end
        n_cmp++; if (count_o !== '0) begin n_err++; $display("FAIL reset_count got %h exp 0", count_o); end
        n_cmp++; if (irq_o !== 1'b0 || escalate_o !== 1'b0) begin n_err++; $display("FAIL reset_irq_esc got %b%b exp 00", irq_o, escalate_o); end
        n_cmp++; if ({inject_o, selftest_fail_o} !== '0) begin n_err++; $display("FAIL reset_inject_fail got %h exp 0", {inject_o, selftest_fail_o}); end
        n_cmp++; if ({selftest_busy_o, selftest_done_o, selftest_pass_o} !== 3'b000) begin n_err++; $display("FAIL reset_st got %b exp 000", {selftest_busy_o, selftest_done_o, selftest_pass_o}); end
    endtask

    task automatic test_basic_count();
        do_reset();
        fault_i = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL basic_irq i=%0d got %b exp 1", i, irq_o); end
            n_cmp++; if (count_o[1*CNT_W +: CNT_W] !== CNT_W'(i)) begin n_err++; $display("FAIL basic_cnt1 i=%0d got %0d exp %0d", i, count_o[1*CNT_W +: CNT_W], i); end
        end
        fault_i = '0;
        tick();
        n_cmp++; if (status_o !== 4'b0010) begin n_err++; $display("FAIL basic_status got %b exp 0010", status_o); end
        n_cmp++; if (count_o !== 32'h0000_0300) begin n_err++; $display("FAIL basic_counts got %h exp 00000300", count_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        threshold_i = 8'd5;
        fault_i     = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_cmp++; if (escalate_o !== m_esc) begin n_err++; $display("FAIL sat_esc i=%0d got %b exp %b", i, escalate_o, m_esc); end
            n_cmp++; if (count_o !== exp_count()) begin n_err++; $display("FAIL sat_count i=%0d got %h exp %h", i, count_o, exp_count()); end
        end
        n_cmp++; if (count_o[CNT_W-1:0] !== 8'd255) begin n_err++; $display("FAIL sat_top got %0d exp 255", count_o[CNT_W-1:0]); end
        fault_i = '0; clear_i = 4'b0001;
        tick();
        clear_i = '0;
        n_cmp++; if (count_o[CNT_W-1:0] !== 8'd0 || status_o[0] !== 1'b0) begin n_err++; $display("FAIL sat_clear got %0d/%b exp 0/0", count_o[CNT_W-1:0], status_o[0]); end
        n_cmp++; if (escalate_o !== 1'b1) begin n_err++; $display("FAIL sat_esc_sticky got %b exp 1", escalate_o); end
    endtask

    task automatic test_mask_clear();
        do_reset();
        threshold_i = '0;
        mask_i = 4'b0100; fault_i = 4'b0100;
        tick();
        fault_i = '0;
        tick();
        n_cmp++; if (status_o !== '0 || count_o !== '0) begin n_err++; $display("FAIL mask_ignored got %b/%h exp 0/0", status_o, count_o); end
        mask_i = '0; fault_i = 4'b0100; clear_i = 4'b0100;
        tick();
        clear_i = '0; fault_i = '0;
        n_cmp++; if (status_o[2] !== 1'b0 || count_o[2*CNT_W +: CNT_W] !== '0) begin n_err++; $display("FAIL clear_prio got %b/%0d exp 0/0", status_o[2], count_o[2*CNT_W +: CNT_W]); end
        fault_i = 4'b0100;
        tick();
        fault_i = '0;
        n_cmp++; if (irq_o !== 1'b1 || status_o !== 4'b0100) begin n_err++; $display("FAIL unmask_count got %b/%b exp 1/0100", irq_o, status_o); end
        mask_i = 4'b0100;
        #1;
        n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL mask_irq_drop got %b exp 0", irq_o); end
        n_cmp++; if (status_o[2] !== 1'b1) begin n_err++; $display("FAIL mask_status_kept got %b exp 1", status_o[2]); end
        mask_i = '0;
        tick();
    endtask

    task automatic test_random_count();
        threshold_i = CNT_W'($urandom_range(3, 12));
        for (int i = 0; i < 200; i++) begin
            fault_i = N_CH'($urandom);
            mask_i  = N_CH'($urandom & $urandom);
            clear_i = ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0;
            tick();
            n_cmp++; if (status_o !== m_status) begin n_err++; $display("FAIL rnd_status i=%0d got %b exp %b", i, status_o, m_status); end
            n_cmp++; if (count_o !== exp_count()) begin n_err++; $display("FAIL rnd_count i=%0d got %h exp %h", i, count_o, exp_count()); end
            n_cmp++; if (irq_o !== (|(m_status & ~mask_i))) begin n_err++; $display("FAIL rnd_irq i=%0d got %b exp %b", i, irq_o, |(m_status & ~mask_i)); end
            n_cmp++; if (escalate_o !== m_esc) begin n_err++; $display("FAIL rnd_esc i=%0d got %b exp %b", i, escalate_o, m_esc); end
        end
        fault_i = '0; mask_i = '0; clear_i = '0;
    endtask

    // Channel c is echoed ECHO_D cycles after its inject if echo_en[c]; abort_r != 0 resets
    // the block in that cycle after the start.
    task automatic run_selftest(input logic [N_CH-1:0] echo_en, input bit noise, input int abort_r);
        int s [N_CH];
        int d [N_CH];
        int total;
        logic [N_CH-1:0] exp_inj, tgt, echo;
        total = 0;
        for (int c = 0; c < N_CH; c++) begin
            d[c]  = echo_en[c] ? 2 + ECHO_D : 2 + int'(TIMEOUT);
            s[c]  = 1 + total;
            total = total + d[c];
        end
        fault_i = '0; clear_i = '0; selftest_start_i = 1'b1; m_supp = '0;
        tick();
        selftest_start_i = 1'b0;
        for (int r = 1; r <= total + 2; r++) begin
            exp_inj = '0; tgt = '0; echo = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (r == s[c]) exp_inj[c] = 1'b1;
                if (r >= s[c] && r < s[c] + d[c]) tgt[c] = 1'b1;
                if (echo_en[c] && r == s[c] + ECHO_D) echo[c] = 1'b1;
            end
            n_cmp++; if (inject_o !== exp_inj) begin n_err++; $display("FAIL st_inject r=%0d got %b exp %b", r, inject_o, exp_inj); end
            n_cmp++; if (selftest_busy_o !== (r <= total)) begin n_err++; $display("FAIL st_busy r=%0d got %b exp %b", r, selftest_busy_o, r <= total); end
            n_cmp++; if (selftest_done_o !== (r == total + 1)) begin n_err++; $display("FAIL st_done r=%0d got %b exp %b", r, selftest_done_o, r == total + 1); end
            n_cmp++; if (status_o !== m_status || count_o !== exp_count()) begin n_err++; $display("FAIL st_counters r=%0d got %b/%h exp %b/%h", r, status_o, count_o, m_status, exp_count()); end
            if (r <= total + 1) begin
                n_cmp++; if (selftest_pass_o !== 1'b0) begin n_err++; $display("FAIL st_pass_low r=%0d got %b exp 0", r, selftest_pass_o); end
            end else begin
                n_cmp++; if (selftest_fail_o !== ~echo_en) begin n_err++; $display("FAIL st_fail got %b exp %b", selftest_fail_o, ~echo_en); end
                n_cmp++; if (selftest_pass_o !== (echo_en == '1)) begin n_err++; $display("FAIL st_pass got %b exp %b", selftest_pass_o, echo_en == '1); end
            end
            if (r == abort_r) begin
                rst_i = 1'b1; fault_i = '0; m_supp = tgt;
                tick();
                rst_i = 1'b0; m_supp = '0;
                n_cmp++; if (inject_o !== '0 || selftest_busy_o !== 1'b0) begin n_err++; $display("FAIL abort got inj %b busy %b exp 0 0", inject_o, selftest_busy_o); end
                n_cmp++; if (status_o !== '0 || count_o !== '0 || selftest_fail_o !== '0) begin n_err++; $display("FAIL abort_clear got %b/%h/%b exp 0", status_o, count_o, selftest_fail_o); end
                return;
            end
            fault_i = echo | (noise ? (N_CH'($urandom) & ~tgt) : '0);
            selftest_start_i = (r == 5); // must be ignored while busy
            m_supp = tgt;
            tick();
            selftest_start_i = 1'b0;
        end
        fault_i = '0; m_supp = '0;
    endtask

    task automatic test_selftest_pass();
        do_reset();
        threshold_i = '0;
        mask_i = 4'b0010;
        run_selftest(4'b1111, 1'b1, 0);
        mask_i = '0;
    endtask

    task automatic test_selftest_fail();
        run_selftest(4'b0111, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        run_selftest(4'b1111, 1'b0, 0);
    endtask

    task automatic test_abort_retry();
        run_selftest(4'b1111, 1'b0, 6);
        run_selftest(4'b1111, 1'b0, 0);
    endtask

    initial begin
        rst_i = 1'b1; fault_i = '0; mask_i = '0; clear_i = '0; threshold_i = '0;
        selftest_start_i = 1'b0; m_supp = '0; m_status = '0; m_esc = 1'b0;
        for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        test_reset();
        test_basic_count();
        test_saturation();
        test_mask_clear();
        test_random_count();
        test_selftest_pass();
        test_selftest_fail();
        test_back_to_back();
        test_abort_retry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
